rf_scoreboard: RTL and testbench

Register-file scoreboard and issue interlock for the pipelined core's 8 x 16-bit register file. Tracks, per register, the number of issued-but-not-written-back writers and stalls the decode/issue stage when an instruction reads a register with a pending write, or would overflow a register's pending count. Sits beside the register file: issue-side inputs come from decode, clear-side inputs come from writeback (the same strobe that drives the register file `write`/`writeregsel`).

---
 rtl/rf_scoreboard.sv | 109 ++++++++++
 tb/tb_rf_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Register-file scoreboard and issue interlock for an 8 x 16-bit
//            register file. Counts issued-but-not-written-back writers per
//            register and stalls issue on RAW hazards or when a destination
//            register's pending count is already at MAX_PENDING.
// Options  : RF_SCOREBOARD_BYPASS_EN - a source whose only pending writer is
//            being written back this cycle is not treated as pending.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_rs_used,
    input  logic       issue_rt_used,
    input  logic [2:0] issue_rs_sel,
    input  logic [2:0] issue_rt_sel,
    input  logic       issue_wr_en,
    input  logic [2:0] issue_wr_sel,
    input  logic       wb_valid,
    input  logic [2:0] wb_sel,
    input  logic       flush,
    output logic       stall,
    output logic [7:0] busy_mask,
    output logic       err
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [8];
    logic             r_err;
    logic [7:0]       w_pend;
    logic [7:0]       w_inc;
    logic [7:0]       w_dec;
    logic             w_full;
    logic             w_fire;
    logic             w_orphan_wb;

    // Source-hazard view of each register (optionally relaxed by WB bypass)
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_pend[i] = (r_cnt[i] != '0);
`ifdef RF_SCOREBOARD_BYPASS_EN
            if ((r_cnt[i] == C_ONE) && wb_valid && (wb_sel == 3'(i))) begin
                w_pend[i] = 1'b0;
            end
`endif
        end
    end

    // Issue interlock; the destination overflow check never uses the bypass
    always_comb begin
        w_full = (r_cnt[issue_wr_sel] == C_MAX);
        stall  = issue_valid & ((issue_rs_used & w_pend[issue_rs_sel]) |
                                (issue_rt_used & w_pend[issue_rt_sel]) |
                                (issue_wr_en   & w_full));
        w_fire = issue_valid & ~stall & ~flush;
    end

    // Per-register increment / guarded decrement strobes
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_inc[i] = w_fire & issue_wr_en & (issue_wr_sel == 3'(i));
            w_dec[i] = wb_valid & (wb_sel == 3'(i)) & (r_cnt[i] != '0);
        end
        w_orphan_wb = wb_valid & ~flush & (r_cnt[wb_sel] == '0);
    end

    // Pending-writer counters; flush kills every in-flight writer
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!rst) begin
                r_cnt[i] <= '0;
            end else if (flush) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + C_ONE;
            end else if (w_dec[i] && !w_inc[i]) begin
                r_cnt[i] <= r_cnt[i] - C_ONE;
            end
        end
    end

    // Sticky protocol error: writeback of a register with no pending writer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_orphan_wb) begin
            r_err <= 1'b1;
        end
    end

    // Busy mask is a pure function of the counter registers
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            busy_mask[i] = (r_cnt[i] != '0);
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_scoreboard
// Purpose  : Scoreboard bench for rf_scoreboard. A driver issues directed and
//            random traffic and pushes the expected stall / busy_mask / err
//            from a count-array reference model; a monitor pops and compares
//            on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;

    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0, issue_rs_used = 1'b0, issue_rt_used = 1'b0;
    logic [2:0] issue_rs_sel = '0, issue_rt_sel = '0, issue_wr_sel = '0, wb_sel = '0;
    logic       issue_wr_en = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic       stall;
    logic [7:0] busy_mask;
    logic       err;

    rf_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_rs_sel(issue_rs_sel),
        .issue_rt_sel(issue_rt_sel), .issue_wr_en(issue_wr_en),
        .issue_wr_sel(issue_wr_sel), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .flush(flush), .stall(stall), .busy_mask(busy_mask), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        bit       s;
        bit [7:0] b;
        bit       e;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;

    // Reference model: number of outstanding writers per register
    int   m_cnt [8];
    bit   m_err;
    int   cyc = 0;

    function automatic bit m_pend(int r, bit wv, int ws);
        if (m_cnt[r] == 0) return 1'b0;
`ifdef RF_SCOREBOARD_BYPASS_EN
        if (m_cnt[r] == 1 && wv && ws == r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // One cycle of stimulus: drive, push expectation, advance model
    task automatic step(bit r, bit iv, bit rsu, int rs, bit rtu, int rt,
                        bit we, int wsel, bit wv, int wbs, bit fl);
        exp_t x;
        bit   st;
        @(posedge clk); #1;
        rst = r; issue_valid = iv; issue_rs_used = rsu; issue_rs_sel = 3'(rs);
        issue_rt_used = rtu; issue_rt_sel = 3'(rt); issue_wr_en = we;
        issue_wr_sel = 3'(wsel); wb_valid = wv; wb_sel = 3'(wbs); flush = fl;
        st = iv && ((rsu && m_pend(rs, wv, wbs)) || (rtu && m_pend(rt, wv, wbs)) ||
                    (we && m_cnt[wsel] == MAXP));
        x.id = cyc; x.s = st; x.e = m_err;
        for (int i = 0; i < 8; i++) x.b[i] = (m_cnt[i] != 0);
        q.push_back(x);
        cyc++;
        if (!r || fl) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            if (!r) m_err = 1'b0;
        end else begin
            if (wv) begin
                if (m_cnt[wbs] == 0) m_err = 1'b1;
                else m_cnt[wbs] = m_cnt[wbs] - 1;
            end
            if (iv && !st && we) m_cnt[wsel] = m_cnt[wsel] + 1;
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_wr(int d);
        step(1, 1, 0, 0, 0, 0, 1, d, 0, 0, 0);
    endtask

    task automatic wb(int d);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, d, 0);
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                tests += 3;
                if (stall !== x.s) begin
                    fails++;
                    $display("FAIL stall cyc=%0d got=%b exp=%b", x.id, stall, x.s);
                end
                if (busy_mask !== x.b) begin
                    fails++;
                    $display("FAIL busy_mask cyc=%0d got=%h exp=%h", x.id, busy_mask, x.b);
                end
                if (err !== x.e) begin
                    fails++;
                    $display("FAIL err cyc=%0d got=%b exp=%b", x.id, err, x.e);
                end
            end
        end
    end

    // Driver: directed scenarios followed by constrained-random traffic
    initial begin
        int pick, n;
        int cand [8];
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with traffic, then release and probe rs_sel=5
        step(0, 1, 1, 5, 0, 0, 1, 2, 1, 4, 0);
        step(0, 1, 1, 5, 0, 0, 1, 2, 1, 4, 0);
        step(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);

        // RAW on r3, writeback, dependent issue
        issue_wr(3);
        step(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
        step(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Overflow on r6
        repeat (3) issue_wr(6);
        issue_wr(6);
        step(1, 1, 0, 0, 0, 0, 1, 6, 1, 6, 0);
        issue_wr(6);
        idle();
        repeat (3) wb(6);
        idle();

        // Simultaneous inc/dec on r2
        issue_wr(2);
        step(1, 1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
        idle();
        wb(2);

        // Flush with busy_mask 8'h36
        issue_wr(1); issue_wr(2); issue_wr(4); issue_wr(5);
        idle();
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        idle();

        // Orphan writeback on r7 -> sticky err until reset
        wb(7);
        issue_wr(7); wb(7); idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            n = 0;
            for (int i = 0; i < 8; i++) if (m_cnt[i] != 0) begin cand[n] = i; n++; end
            if (n > 0 && $urandom_range(0, 9) < 8) pick = cand[$urandom_range(0, n - 1)];
            else pick = $urandom_range(0, 7);
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom), $urandom_range(0, 7),
                 1'($urandom), $urandom_range(0, 7),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                 ($urandom_range(0, 9) < 4), pick,
                 ($urandom_range(0, 99) < 4));
        end
        idle();
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    // Summary after the driver completes, bounded by a hard time limit
    initial begin
        fork
            wait (done);
            #200000;
        join_any
        disable fork;
        @(negedge clk); #1;
        if (!done || q.size() != 0) begin
            fails++;
            $display("FAIL completion done=%b pending=%0d exp done=1 pending=0", done, q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
